// File: rtl/exp_q610_seq.sv
// Iterative exp(x) for signed Q6.10 operands: range reduction by ln2, Horner Taylor
// series for exp(r) in Q2.IFRAC, then a rounded scale by 2^k. One operation in flight.
module exp_q610_seq #(
  parameter int TERMS = 6,
  parameter int IFRAC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] exp_out,
  output logic        out_sat
);

  localparam int AW = IFRAC + 4;
  localparam int PW = 2 * AW + 20;
  localparam int CW = 4;
  localparam logic signed [AW-1:0] ONE = AW'(1) << IFRAC;

  typedef enum logic [2:0] {IDLE, REDUCE, SERIES, SCALE, DONE} state_t;

  state_t state, nxt;

  logic signed [15:0]   x;
  logic signed [7:0]    k;
  logic signed [AW-1:0] r, acc, acc_nxt;
  logic [CW-1:0]        cnt;

  // round(65536 / i)
  function automatic logic signed [PW-1:0] recip(input logic [CW-1:0] i);
    case (i)
      4'd1:    recip = PW'(65536);
      4'd2:    recip = PW'(32768);
      4'd3:    recip = PW'(21845);
      4'd4:    recip = PW'(16384);
      4'd5:    recip = PW'(13107);
      4'd6:    recip = PW'(10923);
      4'd7:    recip = PW'(9362);
      4'd8:    recip = PW'(8192);
      default: recip = '0;
    endcase
  endfunction

  // Range reduction: k = floor(x/ln2), r = x - k*ln2 with ln2 ~ 710/1024
  logic signed [31:0] xw, kprod, kfull, rwide, rsh;
  always_comb begin
    xw    = {{16{x[15]}}, x};
    kprod = xw * 32'sd1477;
    kfull = kprod >>> 20;
    rwide = xw - kfull * 32'sd710;
    rsh   = rwide <<< (IFRAC - 10);
  end

  // One Horner step: acc = ONE + ((acc*r >>> IFRAC) * RECIP[cnt]) >>> 16
  logic signed [PW-1:0] acc_w, r_w, p1, t, p2;
  always_comb begin
    acc_w   = {{(PW-AW){acc[AW-1]}}, acc};
    r_w     = {{(PW-AW){r[AW-1]}}, r};
    p1      = acc_w * r_w;
    t       = p1 >>> IFRAC;
    p2      = (t * recip(cnt)) >>> 16;
    acc_nxt = ONE + p2[AW-1:0];
  end

  // Scale by 2^k: shift right by s = 6 - k with round half up
  logic signed [7:0] s;
  logic [47:0]       accu, sum, shifted;
  logic              sat_k, under, sat_r;
  always_comb begin
    s       = 8'sd6 - k;
    sat_k   = (k >= 8'sd5);
    under   = (s > 8'sd24);
    accu    = {{(48-AW){1'b0}}, acc};
    sum     = accu + (48'd1 << (s[4:0] - 5'd1));
    shifted = sum >> s[4:0];
    sat_r   = (shifted > 48'h7FFF);
  end

  logic unused_bits;
  assign unused_bits = ^{kfull[31:8], rsh[31:AW], p2[PW-1:AW]};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = REDUCE;
      REDUCE:  nxt = SERIES;
      SERIES:  if (cnt == 4'd1) nxt = SCALE;
      SCALE:   nxt = DONE;
      DONE:    if (out_valid && out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      k         <= '0;
      r         <= '0;
      acc       <= '0;
      cnt       <= '0;
      exp_out   <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) x <= x_in;
        REDUCE: begin
          k   <= kfull[7:0];
          r   <= rsh[AW-1:0];
          acc <= ONE;
          cnt <= CW'(TERMS);
        end
        SERIES: begin
          acc <= acc_nxt;
          cnt <= cnt - 4'd1;
        end
        SCALE: begin
          if (sat_k) begin
            exp_out <= 16'h7FFF;
            out_sat <= 1'b1;
          end else if (under) begin
            exp_out <= 16'h0000;
            out_sat <= 1'b0;
          end else if (sat_r) begin
            exp_out <= 16'h7FFF;
            out_sat <= 1'b1;
          end else begin
            exp_out <= shifted[15:0];
            out_sat <= 1'b0;
          end
        end
        // out_valid is registered one cycle into DONE and held until the handshake
        DONE: begin
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_q610_seq.sv
// Directed + randomized bench for exp_q610_seq against an arithmetic model of the
// reduce / Taylor-series / scale rules.
module tb_exp_q610_seq;

  localparam int TERMS = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] exp_out;
  logic        out_sat;

  int vectors = 0;
  int miscompares = 0;
  int n_ops = 0;
  int n_results = 0;

  exp_q610_seq #(.TERMS(TERMS), .IFRAC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && out_valid && out_ready) n_results++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // exp(x) by the block's arithmetic rules, plain integer math
  function automatic void model(input logic [15:0] xv, output logic [15:0] e,
                                output logic so);
    longint xi, k, r, acc, sh, v;
    xi  = longint'($signed(xv));
    k   = (xi * 1477) >>> 20;
    r   = (xi - k * 710) * 64;
    acc = 65536;
    for (int i = TERMS; i >= 1; i--)
      acc = 65536 + ((((acc * r) >>> 16) * ((131072 + i) / (2 * i))) >>> 16);
    sh = 6 - k;
    if (k >= 5) begin
      e = 16'h7FFF; so = 1'b1;
    end else if (sh > 24) begin
      e = 16'h0000; so = 1'b0;
    end else begin
      v = (acc + (longint'(1) << (sh - 1))) >> sh;
      if (v > 32767) begin
        e = 16'h7FFF; so = 1'b1;
      end else begin
        e = 16'(v); so = 1'b0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_op(input logic [15:0] xv);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin tick(); g++; end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x_in = xv;
    tick();
    in_valid = 1'b0;
    x_in = 16'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input logic [15:0] xv, input int stall);
    int lat;
    logic [15:0] e;
    logic so;
    model(xv, e, so);
    start_op(xv);
    n_ops++;
    wait_valid(lat);
    chk("latency", 32'(lat), 32'(TERMS + 3));
    chk("exp_out", 32'(exp_out), 32'(e));
    chk("out_sat", 32'(out_sat), 32'(so));
    repeat (stall) tick();
    if (stall > 0) chk("exp_out_stalled", 32'(exp_out), 32'(e));
    handshake();
  endtask

  initial begin
    int lat;
    logic [15:0] held;

    // reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_exp_out", 32'(exp_out), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // directed values
    run_op(16'h0000, 0);
    chk("x0_exp", 32'(exp_out), 32'h0400);
    chk("x0_sat", 32'(out_sat), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    run_op(16'h0400, 1);
    chk("x1_near_2783", 32'(exp_out >= 16'd2781 && exp_out <= 16'd2785), 32'd1);
    run_op(16'hFC00, 0);
    chk("xm1_near_377", 32'(exp_out >= 16'd375 && exp_out <= 16'd379), 32'd1);
    run_op(16'h1000, 0);
    chk("x4_sat_val", 32'(exp_out), 32'h7FFF);
    chk("x4_sat_flag", 32'(out_sat), 32'd1);
    run_op(16'hE000, 0);
    chk("xm8_zero", 32'(exp_out), 32'h0000);
    chk("xm8_nosat", 32'(out_sat), 32'd0);
    run_op(16'h8000, 2);
    chk("xmin_zero", 32'(exp_out), 32'h0000);

    // busy: inputs toggled while working, then 20 cycles of backpressure
    start_op(16'h0400);
    n_ops++;
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom);
      x_in = 16'($urandom);
      tick();
      lat++;
    end
    chk("busy_latency", 32'(lat), 32'(TERMS + 3));
    held = exp_out;
    chk("busy_result", 32'(exp_out >= 16'd2781 && exp_out <= 16'd2785), 32'd1);
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'($urandom);
      x_in = 16'($urandom);
      tick();
      chk("bp_exp_stable", 32'(exp_out), 32'(held));
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_rise", 32'(in_ready), 32'd1);
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_exp_kept", 32'(exp_out), 32'(held));
    tick();
    chk("bp_no_extra_accept", 32'(in_ready), 32'd1);

    // async reset during the series phase
    start_op(16'h0400);
    tick();
    tick();
    chk("series_busy", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_exp_out", 32'(exp_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_no_result", 32'(out_valid), 32'd0);
    run_op(16'h0B1C, 0);
    chk("x2p777_range", 32'(exp_out >= 16'd16400 && exp_out <= 16'd16500), 32'd1);

    // sweep with random stalls
    for (int xi = -32768; xi <= 3551; xi += 7)
      run_op(16'(xi), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);

    // random operands over the full range
    repeat (150) run_op(16'($urandom), int'($urandom_range(0, 2)));

    tick();
    chk("result_count", 32'(n_results), 32'(n_ops));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
